// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional feature: define CLA_PIPE_SAT_EN to add the sat input (signed saturation on overflow).
// Register level 0 captures the operands; level s+1 holds the result of resolving
// groups s*GPS..s*GPS+GPS-1; level NSTG drives the outputs.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG   = WIDTH / GRP;
    localparam int GP   = (GPS == 0) ? 1 : GPS;
    localparam int NSTG = (NG + GP - 1) / GP;

    if (WIDTH % GRP != 0 || GPS == 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GRP and GPS must be nonzero");
    end

    logic [NSTG:0]                 v, rc, rm, adv;
    logic [NSTG:0][WIDTH-1:0]      rs;
    logic [NSTG-1:0][WIDTH-1:0]    ra, rb, ns;
    logic [NSTG-1:0]               rsat, nc, nm;
    logic                          acc, sat_i;

`ifdef CLA_PIPE_SAT_EN
    assign sat_i = sat;
`else
    assign sat_i = 1'b0;
`endif

    // Carries into every bit of a group plus its carry out, each as a flat G/P sum of products.
    function automatic logic [GRP:0] cla(input logic [GRP-1:0] x, input logic [GRP-1:0] y, input logic ci);
        logic [GRP-1:0] g, p;
        logic [GRP:0]   c;
        logic           t, u;
        g = x & y;
        p = x ^ y;
        c[0] = ci;
        for (int k = 0; k < GRP; k++) begin
            t = ci;
            for (int j = 0; j <= k; j++) t = t & p[j];
            for (int j = 0; j <= k; j++) begin
                u = g[j];
                for (int m = j + 1; m <= k; m++) u = u & p[m];
                t = t | u;
            end
            c[k+1] = t;
        end
        return c;
    endfunction

    assign acc       = in_valid & in_ready;
    assign out_valid = v[NSTG];
    assign sum       = rs[NSTG];
    assign cout      = rc[NSTG];
    assign ovf       = rm[NSTG] ^ rc[NSTG];
    assign zero      = v[NSTG] & ~|rs[NSTG];

    // Backpressure chain: a level moves on when its successor is empty or itself moving on.
    always_comb begin
        logic nx;
        adv = '0;
        nx = v[NSTG] & out_ready;
        adv[NSTG] = nx;
        for (int i = NSTG - 1; i >= 0; i--) begin
            nx = v[i] & (~v[i+1] | nx);
            adv[i] = nx;
        end
        in_ready = ~v[0] | adv[0];
    end

    // Each stage resolves its own groups from the registered carry; last stage applies saturation.
    always_comb begin
        logic [GRP:0] cv;
        logic         c, m;
        ns = '0;
        nc = '0;
        nm = '0;
        cv = '0;
        for (int s = 0; s < NSTG; s++) begin
            ns[s] = rs[s];
            c = rc[s];
            m = rm[s];
            for (int g = 0; g < NG; g++) begin
                if (g / GP == s) begin
                    cv = cla(ra[s][g*GRP +: GRP], rb[s][g*GRP +: GRP], c);
                    ns[s][g*GRP +: GRP] = ra[s][g*GRP +: GRP] ^ rb[s][g*GRP +: GRP] ^ cv[GRP-1:0];
                    m = (g == NG - 1) ? cv[GRP-1] : m;
                    c = cv[GRP];
                end
            end
            nc[s] = c;
            nm[s] = m;
            if (s == NSTG - 1 && rsat[s] && (m ^ c)) ns[s] = {c, {(WIDTH-1){~c}}};
        end
    end

    // Pipeline registers: capture operands on accept, shift each level forward on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= '0;
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            rc   <= '0;
            rm   <= '0;
            rsat <= '0;
        end else begin
            if (acc) begin
                ra[0]   <= a;
                rb[0]   <= sub ? ~b : b;
                rc[0]   <= sub | cin;
                rsat[0] <= sat_i;
            end
            v[0] <= acc | (v[0] & ~adv[0]);
            for (int s = 0; s < NSTG; s++) begin
                v[s+1] <= adv[s] | (v[s+1] & ~adv[s+1]);
                if (adv[s]) begin
                    rs[s+1] <= ns[s];
                    rc[s+1] <= nc[s];
                    rm[s+1] <= nm[s];
                end
            end
            for (int s = 0; s < NSTG - 1; s++) begin
                if (adv[s]) begin
                    ra[s+1]   <= ra[s];
                    rb[s+1]   <= rb[s];
                    rsat[s+1] <= rsat[s];
                end
            end
        end
    end
endmodule
